// File: rtl/md_pkg.sv
// ============================================================================
// md_pkg : shared opcode and state encodings for the E-stage mult/div unit
// Rev 1.0
// ============================================================================
`default_nettype none

package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MFHI  = 3'd4,
    MD_MFLO  = 3'd5,
    MD_MTHI  = 3'd6,
    MD_MTLO  = 3'd7
  } md_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_arith(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e_md_core.sv
// ============================================================================
// e_md_core : combinational {hi,lo} result for mult/multu/div/divu
// Rev 1.0
// ============================================================================
`default_nettype none

module e_md_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  logic               is_signed;
  logic               is_div;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    is_signed   = (op == MD_MULT) || (op == MD_DIV);
    is_div      = (op == MD_DIV) || (op == MD_DIVU);

    // Low 2*WIDTH bits of the extended product are correct for both signednesses
    a_ext       = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext       = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod        = a_ext * b_ext;

    // Sign-magnitude divide; MIN/-1 falls out as quotient MIN, remainder 0
    a_neg       = is_signed & a[WIDTH-1];
    b_neg       = is_signed & b[WIDTH-1];
    a_mag       = a_neg ? (~a + 1'b1) : a;
    b_mag       = b_neg ? (~b + 1'b1) : b;
    div_by_zero = is_div && (b == '0);
    b_safe      = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag       = a_mag / b_safe;
    r_mag       = a_mag % b_safe;
    quot        = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem         = a_neg ? (~r_mag + 1'b1) : r_mag;

    hi = '0;
    lo = '0;
    case (op)
      MD_MULT, MD_MULTU: {hi, lo} = prod;
      MD_DIV, MD_DIVU: begin
        hi = rem;
        lo = quot;
      end
      default: begin
        hi = '0;
        lo = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/e_md_unit.sv
// ============================================================================
// e_md_unit : fixed-latency multiply/divide unit holding HI/LO for the E stage
// Rev 1.0
// ============================================================================
`default_nettype none

module e_md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             E_md_start,
  input  logic [2:0]       E_md_op,
  input  logic [WIDTH-1:0] E_data1,
  input  logic [WIDTH-1:0] E_data2,
  input  logic             E_md_cancel,
  output logic             E_busy,
  output logic [WIDTH-1:0] E_md_out,
  output logic [WIDTH-1:0] E_hi,
  output logic [WIDTH-1:0] E_lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  md_op_e           op;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_dz;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_nx_q, hi_nx_d;
  logic [WIDTH-1:0] lo_nx_q, lo_nx_d;
  logic             commit_ok_q, commit_ok_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  assign op = md_op_e'(E_md_op);

  e_md_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op         (op),
    .a          (E_data1),
    .b          (E_data2),
    .hi         (core_hi),
    .lo         (core_lo),
    .div_by_zero(core_dz)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_nx_d     = hi_nx_q;
    lo_nx_d     = lo_nx_q;
    commit_ok_d = commit_ok_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (E_md_start && !E_md_cancel) begin
          if (is_arith(op)) begin
            state_d     = ST_RUN;
            cnt_d       = ((op == MD_MULT) || (op == MD_MULTU)) ? C_MULT_LOAD : C_DIV_LOAD;
            hi_nx_d     = core_hi;
            lo_nx_d     = core_lo;
            commit_ok_d = !core_dz;
          end else if (op == MD_MTHI) begin
            hi_d = E_data1;
          end else if (op == MD_MTLO) begin
            lo_d = E_data1;
          end
        end
      end
      ST_RUN: begin
        // Cancel outranks the final-cycle commit; starts here are never looked at
        if (E_md_cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (commit_ok_q) begin
            hi_d = hi_nx_q;
            lo_d = lo_nx_q;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_nx_q     <= '0;
      lo_nx_q     <= '0;
      commit_ok_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_nx_q     <= hi_nx_d;
      lo_nx_q     <= lo_nx_d;
      commit_ok_q <= commit_ok_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  always_comb begin
    case (op)
      MD_MFHI: E_md_out = hi_q;
      MD_MFLO: E_md_out = lo_q;
      default: E_md_out = '0;
    endcase
  end

  assign E_busy = (state_q == ST_RUN);
  assign E_hi   = hi_q;
  assign E_lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_e_md_unit.sv
// ============================================================================
// tb_e_md_unit : directed bench for e_md_unit with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_e_md_unit;

  localparam int W     = 32;
  localparam int N_MUL = 5;
  localparam int N_DIV = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         E_md_start;
  logic [2:0]   E_md_op;
  logic [W-1:0] E_data1;
  logic [W-1:0] E_data2;
  logic         E_md_cancel;
  logic         E_busy;
  logic [W-1:0] E_md_out;
  logic [W-1:0] E_hi;
  logic [W-1:0] E_lo;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  e_md_unit #(
    .WIDTH      (W),
    .MULT_CYCLES(N_MUL),
    .DIV_CYCLES (N_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_md_start (E_md_start),
    .E_md_op    (E_md_op),
    .E_data1    (E_data1),
    .E_data2    (E_data2),
    .E_md_cancel(E_md_cancel),
    .E_busy     (E_busy),
    .E_md_out   (E_md_out),
    .E_hi       (E_hi),
    .E_lo       (E_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the architectural definitions
  function automatic void ref_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo, output bit ok);
    longint          sp;
    longint unsigned up;
    ok = 1'b1;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi, lo} = sp;
      end
      OP_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        {hi, lo} = up;
      end
      OP_DIV: begin
        if (b == 0) ok = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = '0;
        end else begin
          lo = $signed(a) / $signed(b);
          hi = $signed(a) % $signed(b);
        end
      end
      default: begin
        if (b == 0) ok = 1'b0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  int           m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           p_ok = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      p_ok   = 1'b0;
    end else if (m_left > 0) begin
      if (E_md_cancel) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0 && p_ok) begin
          m_hi = p_hi;
          m_lo = p_lo;
        end
      end
    end else if (E_md_start && !E_md_cancel) begin
      if (E_md_op <= OP_DIVU) begin
        ref_calc(E_md_op, E_data1, E_data2, p_hi, p_lo, p_ok);
        m_left = (E_md_op <= OP_MULTU) ? N_MUL : N_DIV;
      end else if (E_md_op == OP_MTHI) m_hi = E_data1;
      else if (E_md_op == OP_MTLO) m_lo = E_data1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_model", {31'b0, E_busy}, {31'b0, (m_left > 0)});
      check("hi_model", E_hi, m_hi);
      check("lo_model", E_lo, m_lo);
      check("mdout_model", E_md_out,
            (E_md_op == OP_MFHI) ? m_hi : (E_md_op == OP_MFLO) ? m_lo : '0);
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    E_md_start = 1'b1;
    E_md_op    = op;
    E_data1    = a;
    E_data2    = b;
    @(posedge clk);
    #1;
    E_md_start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns busy cycles seen after the issuing edge; bounded so a stuck unit still reports
  task automatic wait_idle(output int n);
    n = 0;
    while (E_busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (E_busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n     = 1'b0;
    E_md_start  = 1'b0;
    E_md_op     = 3'd0;
    E_data1     = '0;
    E_data2     = '0;
    E_md_cancel = 1'b0;
    step(3);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    step(1);
    check("rst_busy", {31'b0, E_busy}, 32'd0);
    check("rst_hi", E_hi, 32'h0);
    check("rst_lo", E_lo, 32'h0);

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hi", E_hi, 32'hFFFF_FFFF);
    check("mult_lo", E_lo, 32'hFFFF_FFEB);

    E_md_start = 1'b1;
    E_md_op    = OP_MFHI;
    #2;
    check("mfhi", E_md_out, 32'hFFFF_FFFF);
    E_md_op = OP_MFLO;
    #2;
    check("mflo", E_md_out, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    E_md_start = 1'b0;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_hi", E_hi, 32'h1);
    check("multu_lo", E_lo, 32'hFFFF_FFFE);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", n, 32'd10);
    check("div_lo", E_lo, 32'hFFFF_FFFD);
    check("div_hi", E_hi, 32'hFFFF_FFFF);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divmin_lo", E_lo, 32'h8000_0000);
    check("divmin_hi", E_hi, 32'h0);

    do_op(OP_MTHI, 32'h1234, 32'h0);
    check("mthi", E_hi, 32'h1234);
    do_op(OP_MTLO, 32'h5678, 32'h0);
    check("mtlo", E_lo, 32'h5678);
    do_op(OP_DIVU, 32'd99, 32'd0);
    wait_idle(n);
    check("div0_busy_cycles", n, 32'd10);
    check("div0_hi", E_hi, 32'h1234);
    check("div0_lo", E_lo, 32'h5678);

    do_op(OP_MULT, 32'd5, 32'd5);
    step(1);
    E_md_cancel = 1'b1;
    step(1);
    E_md_cancel = 1'b0;
    check("cancel_busy", {31'b0, E_busy}, 32'd0);
    check("cancel_hi", E_hi, 32'h1234);
    check("cancel_lo", E_lo, 32'h5678);

    E_md_cancel = 1'b1;
    do_op(OP_MTHI, 32'hDEAD, 32'h0);
    do_op(OP_MULT, 32'd2, 32'd3);
    E_md_cancel = 1'b0;
    check("startcancel_busy", {31'b0, E_busy}, 32'd0);
    check("startcancel_hi", E_hi, 32'h1234);

    do_op(OP_DIVU, 32'd100, 32'd7);
    do_op(OP_MULT, 32'd3, 32'd3);
    wait_idle(n);
    check("ignored_start_rest", n, 32'd9);
    check("ignored_hi", E_hi, 32'd2);
    check("ignored_lo", E_lo, 32'd14);
    step(3);
    check("ignored_no_restart", {31'b0, E_busy}, 32'd0);

    do_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_idle(n);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    do_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    do_op(OP_MULTU, 32'h8000_0001, 32'hFFFF_FFFF);
    wait_idle(n);

    do_op(OP_DIV, 32'd100, 32'd3);
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, E_busy}, 32'd0);
    check("midrst_hi", E_hi, 32'h0);
    check("midrst_lo", E_lo, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
